tick_debouncer: RTL

- Multi-channel push-button debouncer; sits directly downstream of the clock divider and consumes its div_clock output as a sampling strobe.
- Runs entirely on the system clock. A rising edge on div_clock becomes a one-cycle tick. Each button is accepted only after STABLE_COUNT consecutive ticks agree.
- Outputs clean levels plus single-cycle press and release pulses to downstream FSMs.

---
 rtl/tick_debouncer_pkg.sv | 13 +
 rtl/tick_debouncer_channel.sv | 70 +++++++
 rtl/tick_debouncer.sv | 51 +++++
 3 files changed

// File: rtl/tick_debouncer_pkg.sv
// Shared defaults for the tick-strobed button debouncer, so every instance
// agrees on channel count and stability window unless overridden.
package tick_debouncer_pkg;

    localparam int DEFAULT_WIDTH        = 4;
    localparam int DEFAULT_STABLE_COUNT = 4;

    // Counter width that can hold 0..stable_count (the count never exceeds stable_count-1).
    function automatic int cnt_width(input int stable_count);
        return $clog2(stable_count + 1);
    endfunction

endpackage

// File: rtl/tick_debouncer_channel.sv
// One debounced button: 2-flop synchronizer, tick-gated stability counter,
// debounced level and registered press/release pulses.
module debounce_channel
    import tick_debouncer_pkg::*;
#(
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int CNT_W = cnt_width(STABLE_COUNT);

    logic             s1_q;
    logic             s2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any tick that agrees with the current level restarts the stability window.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (s2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(STABLE_COUNT - 1)) begin
                level_d = s2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= btn_raw;
            s2_q      <= s1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/tick_debouncer.sv
// Multi-channel debouncer sampled on rising edges of the divided clock,
// which is treated purely as data and turned into a one-cycle tick.
module tick_debouncer
    import tick_debouncer_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_clock,
    input  logic [WIDTH-1:0] btn_in,
    output logic             tick,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    logic div_q;
    logic tick_q;

    // div_q resets high so a strobe already high at reset release is not a tick.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q  <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_clock;
            tick_q <= div_clock & ~div_q;
        end
    end

    assign tick = tick_q;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            debounce_channel #(
                .STABLE_COUNT (STABLE_COUNT)
            ) u_ch (
                .clock         (clock),
                .reset         (reset),
                .tick          (tick_q),
                .btn_raw       (btn_in[gi]),
                .level         (btn_level[gi]),
                .press         (btn_press[gi]),
                .release_pulse (btn_release[gi])
            );
        end
    endgenerate

endmodule
